// File: rtl/riscv_irq_arbiter.sv
// riscv_irq_arbiter: 32-line level/edge interrupt capture, mask and priority arbitration into a single request.
// Optional RISCV_IRQ_SYNC_EN adds a 2-flop synchroniser on every interrupt line.
module riscv_irq_arbiter #(
  parameter int NUM_IRQ = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines_i,
  input  logic [NUM_IRQ-1:0] irq_edge_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic [NUM_IRQ-1:0] irq_sec_mask_i,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_ack_id_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  output logic               irq_sec_o,
  output logic [NUM_IRQ-1:0] irq_pending_o
);
  typedef enum logic [1:0] {IDLE, REQ, ACKED} state_t;
  state_t state;
  logic [NUM_IRQ-1:0] lines, line_q, pend_q, pend_d, clr, elig;
  logic [4:0] win, id_q;
  logic sec_q, irq_q;
`ifdef RISCV_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;
  // two-flop synchroniser so lines may be asynchronous to clk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_lines_i;
      sync2_q <= sync1_q;
    end
  assign lines = sync2_q;
`else
  assign lines = irq_lines_i;
`endif
  assign clr = {{(NUM_IRQ-1){1'b0}}, irq_ack_i} << irq_ack_id_i;
  assign pend_d = (irq_edge_i & ((lines & ~line_q) | (pend_q & ~clr))) | (~irq_edge_i & lines);
  assign elig = pend_q & irq_mask_i;
  // highest-numbered eligible line wins
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (elig[i]) win = i[4:0];
  end
  // previous line sample and pending capture; a new edge beats a same-cycle ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      line_q <= '0;
      pend_q <= '0;
    end else begin
      line_q <= lines;
      pend_q <= pend_d;
    end
  // request FSM with registered outputs; ack beats withdrawal, no preemption in REQ
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      id_q  <= '0;
      sec_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (|elig) begin
            state <= REQ;
            id_q  <= win;
            sec_q <= irq_sec_mask_i[win];
            irq_q <= 1'b1;
          end
        REQ:
          if (irq_ack_i) begin
            state <= ACKED;
            sec_q <= 1'b0;
            irq_q <= 1'b0;
          end else if (!elig[id_q]) begin
            state <= IDLE;
            irq_q <= 1'b0;
          end
        default: begin
          state <= IDLE;
          sec_q <= 1'b0;
          irq_q <= 1'b0;
        end
      endcase
    end
  assign irq_o = irq_q;
  assign irq_id_o = id_q;
  assign irq_sec_o = sec_q;
  assign irq_pending_o = pend_q;
endmodule
